// File: rtl/uart_rx_ctrl.sv
// UART receiver: 16x-oversampled start/data/stop framing with a 2-flop rx synchronizer.
// Optional even-parity bit and parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = 3;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY     = 3'd4;
    localparam logic [2:0] AFTER_DATA = PARITY;
`else
    localparam logic [2:0] AFTER_DATA = STOP;
`endif

    logic [2:0]      state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] b;
    logic            rx_meta;
    logic            rx_sync;
    logic            break_hold;
`ifdef UART_RX_PARITY_EN
    logic            par_bit;
`endif

    // A frame whose stop bit sampled low leaves break_hold set, so a held-low
    // line (break) cannot retrigger START until the line has been seen high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            state      <= IDLE;
            s          <= '0;
            n          <= '0;
            b          <= '0;
            frame_err  <= 1'b0;
            break_hold <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            case (state)
                IDLE: begin
                    if (rx_sync) begin
                        break_hold <= 1'b0;
                    end else if (!break_hold) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == SW'(7)) begin
                            if (!rx_sync) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == SW'(15)) begin
                            s <= '0;
                            b <= {rx_sync, b[DBIT-1:1]};
                            if (n == NW'(DBIT - 1)) begin
                                state <= AFTER_DATA;
                            end else begin
                                n <= n + NW'(1);
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (s == SW'(15)) begin
                            par_bit <= rx_sync;
                            state   <= STOP;
                            s       <= '0;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
`endif
                STOP: begin
                    if (s_tick) begin
                        if (s == SW'(SB_TICK - 1)) begin
                            state      <= IDLE;
                            frame_err  <= ~rx_sync;
                            break_hold <= ~rx_sync;
`ifdef UART_RX_PARITY_EN
                            parity_err <= (^b) ^ par_bit;
`endif
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_done_tick = !reset && (state == STOP) && s_tick && (s == SW'(SB_TICK - 1));
    assign dout         = reset ? '0 : b;

endmodule
